// File: rtl/dc_reset_status_ctrl_pkg.sv
// Shared definitions for the Dreamcast reset / status LED controller.
// Holds the LED pin mode encodings and the pulse channel state type.
package dc_reset_status_ctrl_pkg;

    // LED pin mode selected by reset_conf; any other value means "optional reset output"
    localparam logic [7:0] LEDMODE_STATUS = 8'd0;
    localparam logic [7:0] LEDMODE_DC     = 8'd2;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/dc_reset_status_ctrl_glow.sv
// Free-running glow/blink generator for the status LED.
// Build option LED_GLOW_EN: when defined, glow is a triangle-ramp PWM;
// otherwise glow is a 50% duty square blink taken from the counter MSB.
module led_glow_gen #(
    parameter int BITPOS = 26
) (
    input  logic clock,
    input  logic nreset,
    output logic glow
);

    logic [BITPOS:0] g;

    // Free-running counter, wraps modulo 2^(BITPOS+1)
    always_ff @(posedge clock) begin
        if (!nreset) begin
            g <= '0;
        end else begin
            g <= g + 1'b1;
        end
    end

`ifdef LED_GLOW_EN
    // Brightness ramps up over the first half of the period and down over the second
    logic [7:0] ramp;
    assign ramp = g[BITPOS] ? ~g[BITPOS-1 -: 8] : g[BITPOS-1 -: 8];
    assign glow = (g[7:0] < ramp);
`else
    assign glow = g[BITPOS];
`endif

endmodule

// File: rtl/dc_reset_status_ctrl.sv
// Control-domain driver for the Dreamcast reset line, the optional reset
// output and the status LED. Inputs are already synchronised flags.
// Build option LED_GLOW_EN selects PWM glow instead of square blink for
// the status indications (see led_glow_gen).
module dc_reset_status_ctrl
    import dc_reset_status_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 8_000_000,
    parameter int SLOW_BITPOS  = 26,
    parameter int FAST_BITPOS  = 22
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       reset_dc_req,
    input  logic       reset_opt_req,
    input  logic [7:0] reset_conf,
    input  logic       pll_hdmi_ready,
    input  logic       adv7513_ready,
    input  logic       resync,
    input  logic       force_generate,
    output logic       dc_nreset_low,
    output logic       led_out,
    output logic       led_oe
);

    localparam logic [31:0] LAST_CNT = 32'(RESET_CYCLES - 1);

    // Channel 0 drives the DC reset line, channel 1 the optional reset output
    logic [1:0] req;
    logic [1:0] active_nxt;
    logic       slow_glow;
    logic       fast_glow;
    logic       oe_nxt;
    logic       out_nxt;

    assign req = {reset_opt_req, reset_dc_req};

    for (genvar i = 0; i < 2; i++) begin : g_pulse
        pulse_state_t state, state_nxt;
        logic [31:0]  cnt, cnt_nxt;

        // Pulse channel state and counter registers
        always_ff @(posedge clock) begin
            if (!nreset) begin
                state <= PULSE_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // A request always restarts the pulse; otherwise count out RESET_CYCLES
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            if (req[i]) begin
                state_nxt = PULSE_ACTIVE;
                cnt_nxt   = '0;
            end else if (state == PULSE_ACTIVE) begin
                if (cnt == LAST_CNT) begin
                    state_nxt = PULSE_IDLE;
                end
                cnt_nxt = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
            end
        end

        assign active_nxt[i] = (state_nxt == PULSE_ACTIVE);

        if (i == 0) begin : g_dc_out
            assign dc_nreset_low = (state == PULSE_ACTIVE);
        end
    end

    led_glow_gen #(.BITPOS(SLOW_BITPOS)) u_slow_glow (
        .clock  (clock),
        .nreset (nreset),
        .glow   (slow_glow)
    );

    led_glow_gen #(.BITPOS(FAST_BITPOS)) u_fast_glow (
        .clock  (clock),
        .nreset (nreset),
        .glow   (fast_glow)
    );

    // LED pin mux; reset-output modes follow the channel's next state so the
    // pin is aligned with the pulse itself
    always_comb begin
        oe_nxt  = 1'b1;
        out_nxt = 1'b0;
        if (reset_conf == LEDMODE_DC) begin
            oe_nxt = active_nxt[0];
        end else if (reset_conf == LEDMODE_STATUS) begin
            if (!pll_hdmi_ready) begin
                out_nxt = 1'b1;
            end else if (resync || force_generate) begin
                out_nxt = ~fast_glow;
            end else if (adv7513_ready) begin
                out_nxt = 1'b0;
            end else begin
                out_nxt = ~slow_glow;
            end
        end else begin
            oe_nxt = active_nxt[1];
        end
    end

    // Registered LED pin drive
    always_ff @(posedge clock) begin
        if (!nreset) begin
            led_oe  <= 1'b1;
            led_out <= 1'b1;
        end else begin
            led_oe  <= oe_nxt;
            led_out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_dc_reset_status_ctrl.sv
// Bench for dc_reset_status_ctrl: driver pushes expected outputs into a
// queue from a behavioural model, monitor pops and compares after each edge.
module tb_dc_reset_status_ctrl;

    localparam int RC = 16;
    localparam int SB = 10;
    localparam int FB = 9;

    logic       clock = 1'b0;
    logic       nreset;
    logic       reset_dc_req;
    logic       reset_opt_req;
    logic [7:0] reset_conf;
    logic       pll_hdmi_ready;
    logic       adv7513_ready;
    logic       resync;
    logic       force_generate;
    logic       dc_nreset_low;
    logic       led_out;
    logic       led_oe;

    always #5 clock = ~clock;

    dc_reset_status_ctrl #(
        .RESET_CYCLES (RC),
        .SLOW_BITPOS  (SB),
        .FAST_BITPOS  (FB)
    ) dut (
        .clock          (clock),
        .nreset         (nreset),
        .reset_dc_req   (reset_dc_req),
        .reset_opt_req  (reset_opt_req),
        .reset_conf     (reset_conf),
        .pll_hdmi_ready (pll_hdmi_ready),
        .adv7513_ready  (adv7513_ready),
        .resync         (resync),
        .force_generate (force_generate),
        .dc_nreset_low  (dc_nreset_low),
        .led_out        (led_out),
        .led_oe         (led_oe)
    );

    typedef struct packed {
        logic dc;
        logic oe;
        logic out;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: remaining pulse cycles per channel and cycles since reset
    int dc_left  = 0;
    int opt_left = 0;
    int age      = 0;

    function automatic bit glow_of(input int a, input int bp);
        int ph;
        int b;
        ph = a % (1 << (bp + 1));
`ifdef LED_GLOW_EN
        b = (ph >> (bp - 8)) & 255;
        if (ph >= (1 << bp)) b = 255 - b;
        return (ph & 255) < b;
`else
        b = 0;
        return ph >= (1 << bp);
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Apply current inputs for one clock; predict outputs after the coming edge
    task automatic cyc();
        exp_t e;
        bit   sg, fgl;
        if (!nreset) begin
            dc_left  = 0;
            opt_left = 0;
            age      = 0;
            e        = '{dc: 1'b0, oe: 1'b1, out: 1'b1};
        end else begin
            if (reset_dc_req)       dc_left = RC;
            else if (dc_left > 0)   dc_left--;
            if (reset_opt_req)      opt_left = RC;
            else if (opt_left > 0)  opt_left--;
            sg  = glow_of(age, SB);
            fgl = glow_of(age, FB);
            age++;
            e.dc = (dc_left > 0);
            if (reset_conf == 8'd2) begin
                e.oe  = (dc_left > 0);
                e.out = 1'b0;
            end else if (reset_conf == 8'd0) begin
                e.oe = 1'b1;
                if (!pll_hdmi_ready)              e.out = 1'b1;
                else if (resync || force_generate) e.out = ~fgl;
                else if (adv7513_ready)           e.out = 1'b0;
                else                              e.out = ~sg;
            end else begin
                e.oe  = (opt_left > 0);
                e.out = 1'b0;
            end
        end
        expq.push_back(e);
        @(negedge clock);
        reset_dc_req  = 1'b0;
        reset_opt_req = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        repeat (3) cyc();
        nreset = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the predicted queue after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("dc_nreset_low", dc_nreset_low, e.dc);
                chk("led_oe", led_oe, e.oe);
                chk("led_out", led_out, e.out);
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        nreset = 1'b0;
        reset_dc_req = 1'b0;
        reset_opt_req = 1'b0;
        reset_conf = 8'd0;
        pll_hdmi_ready = 1'b0;
        adv7513_ready = 1'b0;
        resync = 1'b0;
        force_generate = 1'b0;
        @(negedge clock);

        // Reset then idle: no spontaneous pulse
        do_reset();
        repeat (100) cyc();

        // Single DC pulse, then retrigger
        do_reset();
        for (int i = 0; i < 40; i++) begin
            reset_dc_req = (i == 10);
            cyc();
        end
        do_reset();
        for (int i = 0; i < 50; i++) begin
            reset_dc_req = (i == 10) || (i == 20);
            cyc();
        end

        // Status LED priorities and glow rates
        do_reset();
        reset_conf = 8'd0;
        repeat (20) cyc();
        pll_hdmi_ready = 1'b1;
        resync = 1'b1;
        repeat (2200) cyc();
        adv7513_ready = 1'b1;
        resync = 1'b0;
        repeat (50) cyc();
        adv7513_ready = 1'b0;
        repeat (4200) cyc();
        force_generate = 1'b1;
        repeat (300) cyc();
        force_generate = 1'b0;

        // Optional reset output on the LED pin
        reset_conf = 8'd5;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            reset_opt_req = (i == 5);
            cyc();
        end

        // DC reset mirrored on the LED pin, with mode change mid-pulse
        reset_conf = 8'd2;
        for (int i = 0; i < 40; i++) begin
            reset_dc_req = (i == 3);
            if (i == 10) reset_conf = 8'd0;
            if (i == 14) reset_conf = 8'd2;
            cyc();
        end

        // nreset mid-pulse aborts it with no resumption
        do_reset();
        for (int i = 0; i < 40; i++) begin
            reset_dc_req = (i == 2);
            nreset = !(i == 11 || i == 12);
            cyc();
        end
        nreset = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 6000; i++) begin
            nreset        = ($urandom_range(0, 299) != 0);
            reset_dc_req  = ($urandom_range(0, 29) == 0);
            reset_opt_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: reset_conf = 8'd0;
                    1: reset_conf = 8'd2;
                    2: reset_conf = 8'd5;
                    default: reset_conf = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 49) == 0) pll_hdmi_ready = ~pll_hdmi_ready;
            if ($urandom_range(0, 49) == 0) adv7513_ready  = ~adv7513_ready;
            if ($urandom_range(0, 49) == 0) resync         = ~resync;
            if ($urandom_range(0, 49) == 0) force_generate = ~force_generate;
            cyc();
        end
        nreset = 1'b1;

        @(negedge clock);
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
